// File: rtl/sha_msg_feeder_pkg.sv
// Shared definitions for the SHA-256 message feeder: FSM encoding and bus widths.
package sha_msg_feeder_pkg;

    localparam int DIGEST_W = 256;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_STOP,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sha_byte_sel.sv
// Combinational byte picker: selects message byte cnt (forward) or msg_len-1-cnt (reverse).
module sha_byte_sel
    import sha_msg_feeder_pkg::*;
#(
    parameter int MAX_BYTES = 32,
    parameter int LEN_W     = 6
) (
    input  logic [BYTE_W*MAX_BYTES-1:0] msg,
    input  logic [LEN_W-1:0]            msg_len,
    input  logic                        order,
    input  logic [LEN_W-1:0]            cnt,
    output logic [BYTE_W-1:0]           byte_out
);

    logic [LEN_W-1:0] idx;

    // Out-of-range indices (only reachable when the result is unused) read as zero.
    always_comb begin
        idx      = order ? (msg_len - cnt - LEN_W'(1)) : cnt;
        byte_out = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx == LEN_W'(k)) byte_out = msg[BYTE_W*k +: BYTE_W];
        end
    end

endmodule

// File: rtl/sha_msg_feeder.sv
// Message front-end for the SHA-256 core: latch a candidate, stream it byte-wise,
// wait for the digest under a timeout and compare against the target.
module sha_msg_feeder
    import sha_msg_feeder_pkg::*;
#(
    parameter int MAX_BYTES   = 32,
    parameter int LEN_W       = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BYTE_W*MAX_BYTES-1:0] msg,
    input  logic [LEN_W-1:0]            msg_len,
    input  logic                        msg_order,
    input  logic                        cmp_en,
    input  logic [DIGEST_W-1:0]         target,
    output logic                        busy,
    output logic                        done,
    output logic [DIGEST_W-1:0]         digest,
    output logic                        match,
    output logic                        err_len,
    output logic                        err_ovf,
    output logic                        err_timeout,
    output logic                        core_rst_n,
    output logic                        core_byte_rdy,
    output logic                        core_byte_stop,
    output logic [BYTE_W-1:0]           core_data,
    input  logic                        core_ovf,
    input  logic [DIGEST_W-1:0]         core_digest,
    input  logic                        core_done,
    output state_t                      state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Handshake: start is a request sampled only in IDLE (no queueing); every accepted
    // request ends with exactly one done pulse unless reset aborts it.
    state_t                      state;
    logic [BYTE_W*MAX_BYTES-1:0] msg_l;
    logic [LEN_W-1:0]            len_l;
    logic                        order_l;
    logic                        cmp_l;
    logic [DIGEST_W-1:0]         target_l;
    logic [LEN_W-1:0]            cnt;
    logic [TW-1:0]               tcnt;
    logic [BYTE_W-1:0]           sel_byte;

    assign state_dbg = state;

    sha_byte_sel #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_byte_sel (
        .msg      (msg_l),
        .msg_len  (len_l),
        .order    (order_l),
        .cnt      (cnt),
        .byte_out (sel_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            digest         <= '0;
            match          <= 1'b0;
            err_len        <= 1'b0;
            err_ovf        <= 1'b0;
            err_timeout    <= 1'b0;
            core_rst_n     <= 1'b0;
            core_byte_rdy  <= 1'b0;
            core_byte_stop <= 1'b0;
            core_data      <= '0;
            msg_l          <= '0;
            len_l          <= '0;
            order_l        <= 1'b0;
            cmp_l          <= 1'b0;
            target_l       <= '0;
            cnt            <= '0;
            tcnt           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        msg_l       <= msg;
                        len_l       <= msg_len;
                        order_l     <= msg_order;
                        cmp_l       <= cmp_en;
                        target_l    <= target;
                        digest      <= '0;
                        match       <= 1'b0;
                        err_len     <= 1'b0;
                        err_ovf     <= 1'b0;
                        err_timeout <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        if (msg_len > LEN_W'(MAX_BYTES)) begin
                            err_len <= 1'b1;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    core_rst_n <= 1'b1;
                    if (len_l == '0) begin
                        core_byte_stop <= 1'b1;
                        state          <= ST_STOP;
                    end else begin
                        core_byte_rdy <= 1'b1;
                        core_data     <= sel_byte;
                        cnt           <= cnt + LEN_W'(1);
                        state         <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (core_ovf) begin
                        err_ovf        <= 1'b1;
                        done           <= 1'b1;
                        core_rst_n     <= 1'b0;
                        core_byte_rdy  <= 1'b0;
                        core_byte_stop <= 1'b0;
                        core_data      <= '0;
                        state          <= ST_DONE;
                    end else if (cnt == len_l) begin
                        core_byte_rdy  <= 1'b0;
                        core_byte_stop <= 1'b1;
                        core_data      <= '0;
                        state          <= ST_STOP;
                    end else begin
                        core_data <= sel_byte;
                        cnt       <= cnt + LEN_W'(1);
                    end
                end
                ST_STOP: begin
                    tcnt <= '0;
                    if (core_ovf) begin
                        err_ovf        <= 1'b1;
                        done           <= 1'b1;
                        core_rst_n     <= 1'b0;
                        core_byte_stop <= 1'b0;
                        state          <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Overflow outranks a simultaneous core_done: the digest is not trusted.
                    if (core_ovf || core_done || tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        done           <= 1'b1;
                        core_rst_n     <= 1'b0;
                        core_byte_stop <= 1'b0;
                        state          <= ST_DONE;
                        if (core_ovf)       err_ovf     <= 1'b1;
                        else if (core_done) digest      <= core_digest;
                        else                err_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    match <= cmp_l && (digest == target_l) && !(err_len || err_ovf || err_timeout);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Directed bench for sha_msg_feeder with a behavioural SHA core and queue-based scoreboards.
module tb_sha_msg_feeder;
    import sha_msg_feeder_pkg::*;

    localparam int MAXB  = 32;
    localparam int LW    = 6;
    localparam int TO    = 20;
    localparam int LAT   = 3;
    localparam int RES_W = 293;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_OTHER = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [255:0]  msg = '0;
    logic [LW-1:0] msg_len = '0;
    logic          msg_order = 1'b0;
    logic          cmp_en = 1'b0;
    logic [255:0]  target = '0;
    logic          busy, done, match, err_len, err_ovf, err_timeout;
    logic [255:0]  digest;
    logic          core_rst_n, core_byte_rdy, core_byte_stop;
    logic [7:0]    core_data;
    logic          core_ovf = 1'b0;
    logic [255:0]  core_digest = '0;
    logic          core_done = 1'b0;
    state_t        state_dbg;

    sha_msg_feeder #(.MAX_BYTES(MAXB), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .msg(msg), .msg_len(msg_len),
        .msg_order(msg_order), .cmp_en(cmp_en), .target(target), .busy(busy), .done(done),
        .digest(digest), .match(match), .err_len(err_len), .err_ovf(err_ovf),
        .err_timeout(err_timeout), .core_rst_n(core_rst_n), .core_byte_rdy(core_byte_rdy),
        .core_byte_stop(core_byte_stop), .core_data(core_data), .core_ovf(core_ovf),
        .core_digest(core_digest), .core_done(core_done), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]       exp_byte_q[$];
    logic [RES_W-1:0] exp_res_q[$];

    task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] mk_res(input int stop_c, input int rst_c, input bit m,
                                                 input bit el, input bit eo, input bit et,
                                                 input logic [255:0] dig);
        return {16'(stop_c), 16'(rst_c), 1'b0, m, el, eo, et, dig};
    endfunction

    // ---------------- behavioural core ----------------
    logic [7:0] rx_q[$];
    bit stopped = 0;
    int lat = 0;
    int nbytes = 0;
    bit withhold = 0;
    int ovf_at = -1;

    always @(negedge clk) begin
        if (!core_rst_n) begin
            rx_q.delete();
            stopped = 0; lat = 0; nbytes = 0;
            core_done = 1'b0; core_ovf = 1'b0; core_digest = '0;
        end else begin
            core_done = 1'b0;
            core_ovf  = 1'b0;
            if (core_byte_rdy) begin
                rx_q.push_back(core_data);
                nbytes++;
                if (nbytes == ovf_at) core_ovf = 1'b1;
            end
            if (core_byte_stop && !stopped) begin
                stopped = 1;
                lat = LAT;
            end else if (stopped && lat > 0) begin
                lat--;
                if (lat == 0 && !withhold) begin
                    core_done = 1'b1;
                    if (rx_q.size() == 3 && rx_q[0] == 8'h61 && rx_q[1] == 8'h62 && rx_q[2] == 8'h63)
                        core_digest = DIG_ABC;
                    else if (rx_q.size() == 0)
                        core_digest = DIG_EMPTY;
                    else
                        core_digest = DIG_OTHER;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int stop_c = 0;
    int rst_c = 0;

    always @(negedge clk) begin
        if (reset || state_dbg == ST_IDLE) begin
            stop_c = 0; rst_c = 0;
        end else begin
            if (core_byte_stop) stop_c++;
            if (core_rst_n) rst_c++;
        end
    end

    always @(negedge clk) begin
        if (core_byte_rdy) begin
            if (exp_byte_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL core_data: got unexpected byte %0h expected none", core_data);
            end else begin
                chk("core_data", RES_W'(core_data), RES_W'(exp_byte_q.pop_front()));
            end
        end
    end

    // Match is registered in DONE, so it is sampled one cycle after the done pulse.
    always begin
        logic [255:0] c_dig;
        logic c_el, c_eo, c_et;
        int c_stop, c_rst;
        @(negedge clk);
        if (done) begin
            c_dig = digest; c_el = err_len; c_eo = err_ovf; c_et = err_timeout;
            c_stop = stop_c; c_rst = rst_c;
            @(negedge clk);
            if (exp_res_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL result: got unexpected done expected none");
            end else begin
                chk("result", {16'(c_stop), 16'(c_rst), done, match, c_el, c_eo, c_et, c_dig},
                    exp_res_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [255:0] m, input int len, input bit ord, input bit ce,
                         input logic [255:0] tgt);
        @(negedge clk);
        msg = m; msg_len = LW'(len); msg_order = ord; cmp_en = ce; target = tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: got busy after 200 cycles expected idle", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, RES_W'(busy), '0);
        chk({tag, "_done"}, RES_W'(done), '0);
        chk({tag, "_match"}, RES_W'(match), '0);
        chk({tag, "_digest"}, RES_W'(digest), '0);
        chk({tag, "_err_len"}, RES_W'(err_len), '0);
        chk({tag, "_err_ovf"}, RES_W'(err_ovf), '0);
        chk({tag, "_err_timeout"}, RES_W'(err_timeout), '0);
        chk({tag, "_core_rst_n"}, RES_W'(core_rst_n), '0);
        chk({tag, "_byte_rdy"}, RES_W'(core_byte_rdy), '0);
        chk({tag, "_byte_stop"}, RES_W'(core_byte_stop), '0);
        chk({tag, "_core_data"}, RES_W'(core_data), '0);
        chk({tag, "_state"}, RES_W'(state_dbg), RES_W'(ST_IDLE));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: "abc", forward, compare enabled
        exp_byte_q.push_back(8'h61); exp_byte_q.push_back(8'h62); exp_byte_q.push_back(8'h63);
        exp_res_q.push_back(mk_res(1 + LAT, 3 + 1 + LAT, 1, 0, 0, 0, DIG_ABC));
        issue(256'h636261, 3, 0, 1, DIG_ABC);
        wait_idle("t1");

        // 2: "abc", reversed, compare disabled although digest equals target
        exp_byte_q.push_back(8'h63); exp_byte_q.push_back(8'h62); exp_byte_q.push_back(8'h61);
        exp_res_q.push_back(mk_res(1 + LAT, 3 + 1 + LAT, 0, 0, 0, 0, DIG_OTHER));
        issue(256'h636261, 3, 1, 0, DIG_OTHER);
        wait_idle("t2");

        // 3: empty message
        exp_res_q.push_back(mk_res(1 + LAT, 1 + LAT, 1, 0, 0, 0, DIG_EMPTY));
        issue(256'h0, 0, 0, 1, DIG_EMPTY);
        wait_idle("t3");

        // 4: length one past the maximum, core never released
        exp_res_q.push_back(mk_res(0, 0, 0, 1, 0, 0, '0));
        issue(256'h636261, MAXB + 1, 0, 1, DIG_ABC);
        wait_idle("t4");

        // 5a: core withholds done, target 0 so an ungated compare would match
        withhold = 1;
        exp_byte_q.push_back(8'h61); exp_byte_q.push_back(8'h62); exp_byte_q.push_back(8'h63);
        exp_res_q.push_back(mk_res(1 + TO, 3 + 1 + TO, 0, 0, 0, 1, '0));
        issue(256'h636261, 3, 0, 1, '0);
        wait_idle("t5a");
        withhold = 0;

        // 5b: overflow after the second of four bytes
        ovf_at = 2;
        exp_byte_q.push_back(8'h11); exp_byte_q.push_back(8'h22);
        exp_res_q.push_back(mk_res(0, 2, 0, 0, 1, 0, '0));
        issue(256'h44332211, 4, 0, 1, '0);
        wait_idle("t5b");
        ovf_at = -1;

        // 7: maximum length, reversed; byte k holds k+1
        for (int i = 0; i < MAXB; i++) exp_byte_q.push_back(8'(MAXB - i));
        exp_res_q.push_back(mk_res(1 + LAT, MAXB + 1 + LAT, 0, 0, 0, 0, DIG_OTHER));
        issue(256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201, MAXB, 1, 0, '0);
        wait_idle("t7");

        // 6a: start pulses while busy are ignored
        exp_byte_q.push_back(8'h61); exp_byte_q.push_back(8'h62); exp_byte_q.push_back(8'h63);
        exp_res_q.push_back(mk_res(1 + LAT, 3 + 1 + LAT, 1, 0, 0, 0, DIG_ABC));
        issue(256'h636261, 3, 0, 1, DIG_ABC);
        @(negedge clk);
        msg = 256'h7a; msg_len = LW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t6a");

        // 6b: reset during FEED after three bytes; no done expected
        exp_byte_q.push_back(8'h01); exp_byte_q.push_back(8'h02); exp_byte_q.push_back(8'h03);
        issue(256'h0807060504030201, 8, 0, 1, DIG_ABC);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 6c: next request completes normally ("hello" reversed)
        exp_byte_q.push_back(8'h6f); exp_byte_q.push_back(8'h6c); exp_byte_q.push_back(8'h6c);
        exp_byte_q.push_back(8'h65); exp_byte_q.push_back(8'h68);
        exp_res_q.push_back(mk_res(1 + LAT, 5 + 1 + LAT, 1, 0, 0, 0, DIG_OTHER));
        issue(256'h6f6c6c6568, 5, 1, 1, DIG_OTHER);
        wait_idle("t6c");

        repeat (5) @(negedge clk);
        chk("byte_queue_left", RES_W'(exp_byte_q.size()), '0);
        chk("result_queue_left", RES_W'(exp_res_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
